serial_subtractor: RTL and testbench

Parametrised, multi-cycle two's-complement subtractor computing result = a − b, DIGIT bits per clock, LSB digit first, with a ripple borrow held between cycles. Adds a start/busy/done handshake, borrow and signed-overflow flags, and selectable wrap / unsigned-saturate / signed-saturate modes. It is the sequential, width-generic successor to the 8-bit combinational subtractor and serves arithmetic datapaths that trade latency for area.

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: result = a - b, DIGIT bits per clock,
// LSB digit first, with wrap / unsigned-saturate / signed-saturate result modes.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(N - 1);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, raw_q, raw_d;
  logic [1:0]       mode_q, mode_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             borrow_q, borrow_d, overflow_q, overflow_d, done_q, done_d;

  logic [DIGIT:0]   diff;
  logic [WIDTH-1:0] raw_full;
  logic             ovf;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    raw_d      = raw_q;
    bin_d      = bin_q;
    result_d   = result_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    // Slice difference; the extra top bit is the digit's borrow out.
    diff = {1'b0, a_q[cnt_q*DIGIT +: DIGIT]} - {1'b0, b_q[cnt_q*DIGIT +: DIGIT]}
         - {{DIGIT{1'b0}}, bin_q};
    raw_full = raw_q;
    raw_full[cnt_q*DIGIT +: DIGIT] = diff[DIGIT-1:0];
    ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw_full[WIDTH-1] != a_q[WIDTH-1]);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          cnt_d   = '0;
          bin_d   = 1'b0;
          raw_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        raw_d = raw_full;
        bin_d = diff[DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          state_d    = IDLE;
          done_d     = 1'b1;
          borrow_d   = diff[DIGIT];
          overflow_d = ovf;
          case (mode_q)
            2'b01:   result_d = diff[DIGIT] ? '0 : raw_full;
            2'b10:   result_d = ovf ? (a_q[WIDTH-1] ? SAT_MIN : SAT_MAX) : raw_full;
            default: result_d = raw_full;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      raw_q      <= '0;
      bin_q      <= 1'b0;
      result_q   <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      raw_q      <= raw_d;
      bin_q      <= bin_d;
      result_q   <= result_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table on the 8/2 build plus
// handshake, reset and parameter-variant sequences.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8, DIGIT=2
  logic       m_start;
  logic [7:0] m_a, m_b;
  logic [1:0] m_mode;
  logic       m_busy, m_done, m_borrow, m_ovf;
  logic [7:0] m_result;

  // WIDTH=16, DIGIT=4
  logic        w_start;
  logic [15:0] w_a, w_b;
  logic [1:0]  w_mode;
  logic        w_busy, w_done, w_borrow, w_ovf;
  logic [15:0] w_result;

  // WIDTH=8, DIGIT=8
  logic       n_start;
  logic [7:0] n_a, n_b;
  logic [1:0] n_mode;
  logic       n_busy, n_done, n_borrow, n_ovf;
  logic [7:0] n_result;

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_main (
    .clk(clk), .rst(rst), .start(m_start), .a(m_a), .b(m_b), .mode(m_mode),
    .busy(m_busy), .done(m_done), .result(m_result), .borrow(m_borrow), .overflow(m_ovf)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_wide (
    .clk(clk), .rst(rst), .start(w_start), .a(w_a), .b(w_b), .mode(w_mode),
    .busy(w_busy), .done(w_done), .result(w_result), .borrow(w_borrow), .overflow(w_ovf)
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_one (
    .clk(clk), .rst(rst), .start(n_start), .a(n_a), .b(n_b), .mode(n_mode),
    .busy(n_busy), .done(n_done), .result(n_result), .borrow(n_borrow), .overflow(n_ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (sampling/driving point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic [7:0] res;
    logic       brw;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  // Full operation on the 8/2 build with cycle-by-cycle handshake checks;
  // inputs are scrambled during RUN to confirm they are ignored.
  task automatic run_main(input vec_t v, input int idx);
    m_a = v.a; m_b = v.b; m_mode = v.mode; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    m_a = ~v.a; m_b = ~v.b; m_mode = ~v.mode;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("v%0d busy c%0d", idx, k), {31'b0, m_busy}, 32'd1);
      check($sformatf("v%0d done c%0d", idx, k), {31'b0, m_done}, 32'd0);
      tick();
    end
    check($sformatf("v%0d done c5", idx), {31'b0, m_done}, 32'd1);
    check($sformatf("v%0d busy c5", idx), {31'b0, m_busy}, 32'd0);
    check($sformatf("v%0d result", idx), {24'b0, m_result}, {24'b0, v.res});
    check($sformatf("v%0d borrow", idx), {31'b0, m_borrow}, {31'b0, v.brw});
    check($sformatf("v%0d overflow", idx), {31'b0, m_ovf}, {31'b0, v.ovf});
    tick();
    check($sformatf("v%0d done drop", idx), {31'b0, m_done}, 32'd0);
    check($sformatf("v%0d result hold", idx), {24'b0, m_result}, {24'b0, v.res});
  endtask

  int dones;

  initial begin
    vecs[0] = '{8'h03, 8'h01, 2'b00, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 8'h05, 2'b00, 8'hFD, 1'b1, 1'b0};
    vecs[2] = '{8'h02, 8'h05, 2'b01, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hF8, 8'h02, 2'b01, 8'hF6, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 2'b00, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h01, 2'b10, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'hFF, 2'b10, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{8'h4C, 8'h15, 2'b10, 8'h37, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 2'b11, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{8'h00, 8'h01, 2'b01, 8'h00, 1'b1, 1'b0};

    rst = 1'b1;
    m_start = 1'b0; m_a = '0; m_b = '0; m_mode = '0;
    w_start = 1'b0; w_a = '0; w_b = '0; w_mode = '0;
    n_start = 1'b0; n_a = '0; n_b = '0; n_mode = '0;
    tick(); tick();
    rst = 1'b0;

    check("reset busy", {31'b0, m_busy}, 32'd0);
    check("reset done", {31'b0, m_done}, 32'd0);
    check("reset result", {24'b0, m_result}, 32'd0);
    check("reset borrow", {31'b0, m_borrow}, 32'd0);
    check("reset overflow", {31'b0, m_ovf}, 32'd0);

    for (int i = 0; i < 10; i++) run_main(vecs[i], i);

    // Start during busy is ignored; start in the done cycle is accepted.
    m_a = 8'h0E; m_b = 8'h07; m_mode = 2'b00; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        m_a = 8'hFF; m_b = 8'h00; m_start = 1'b1;
      end else begin
        m_start = 1'b0;
      end
      if (m_done) dones++;
      tick();
    end
    check("hs done count", dones, 0);
    check("hs done c5", {31'b0, m_done}, 32'd1);
    check("hs result", {24'b0, m_result}, 32'h07);
    m_a = 8'hC6; m_b = 8'h85; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    check("hs2 busy c1", {31'b0, m_busy}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      if (m_done) dones++;
      tick();
    end
    check("hs2 no early done", dones, 0);
    check("hs2 done c5", {31'b0, m_done}, 32'd1);
    check("hs2 result", {24'b0, m_result}, 32'h41);
    check("hs2 borrow", {31'b0, m_borrow}, 32'd0);
    tick();

    // Reset mid-operation.
    m_a = 8'h71; m_b = 8'h39; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst busy", {31'b0, m_busy}, 32'd0);
    check("rst done", {31'b0, m_done}, 32'd0);
    check("rst result", {24'b0, m_result}, 32'd0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (m_done || m_busy) dones++;
      tick();
    end
    check("rst no activity", dones, 0);
    run_main('{8'h81, 8'h81, 2'b00, 8'h00, 1'b0, 1'b0}, 100);

    // WIDTH=16, DIGIT=4: N=4, done in cycle 5.
    w_a = 16'h1234; w_b = 16'h0235; w_mode = 2'b00; w_start = 1'b1;
    tick();
    w_start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 4; k++) begin
      if (w_done || !w_busy) dones++;
      tick();
    end
    check("w16 busy/done c1-4", dones, 0);
    check("w16 done c5", {31'b0, w_done}, 32'd1);
    check("w16 result", {16'b0, w_result}, 32'h0FFF);
    check("w16 borrow", {31'b0, w_borrow}, 32'd0);

    // WIDTH=8, DIGIT=8: N=1, done in cycle 2.
    n_a = 8'h55; n_b = 8'h0F; n_mode = 2'b00; n_start = 1'b1;
    tick();
    n_start = 1'b0;
    check("n1 busy c1", {31'b0, n_busy}, 32'd1);
    check("n1 done c1", {31'b0, n_done}, 32'd0);
    tick();
    check("n1 done c2", {31'b0, n_done}, 32'd1);
    check("n1 result", {24'b0, n_result}, 32'h46);
    check("n1 overflow", {31'b0, n_ovf}, 32'd0);
    tick();
    check("n1 done drop", {31'b0, n_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
